// File: rtl/cache_line_store.sv
// -----------------------------------------------------------------------------
// cache_line_store
// Direct-mapped cache data array with a critical-word-first burst refill
// engine. Tags and valid bits are kept by the cache controller; this block only
// stores line data.
//   - Read hit   : word [index][offset] returned one cycle later (o_rvalid).
//   - Write hit  : byte-strobed write-through update of [index][offset].
//   - Write miss : ignored (no write allocate).
//   - Read miss  : burst refill starting at the missed word, wrapping within
//                  the line; the first beat is forwarded to o_rdata at once.
//
// Optional feature macro: CACHE_PARITY_EN
//   When defined, each word carries an even-parity bit, checked on read hits
//   and reported on o_par_err together with o_rvalid. When undefined,
//   o_par_err is tied low.
//
// Ports
//   i_clk           clock, all state on the rising edge
//   i_reset_n       asynchronous active-low reset
//   i_rd_en/i_wr_en core read / write request (never both high)
//   i_hit           controller tag match for i_index
//   i_index         set index
//   i_offset        word offset within the line
//   i_wdata/i_wstrb store data and byte enables
//   i_refill_valid  refill beat valid
//   i_refill_data   refill beat data
//   o_refill_ready  refill beats accepted (REFILL state)
//   o_refill_done   one-cycle pulse after the last beat
//   o_rdata         registered read data, held between o_rvalid pulses
//   o_rvalid        one-cycle read data qualifier
//   o_par_err       parity error, qualified by o_rvalid
//   o_busy          refill in progress
// -----------------------------------------------------------------------------
module cache_line_store #(
   parameter  int DATA_W         = 32,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int SETS           = 32,
   localparam int OFF_W          = $clog2(WORDS_PER_LINE),
   localparam int IDX_W          = $clog2(SETS),
   localparam int NBYTES         = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_rd_en,
   input  logic              i_wr_en,
   input  logic              i_hit,
   input  logic [IDX_W-1:0]  i_index,
   input  logic [OFF_W-1:0]  i_offset,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [NBYTES-1:0] i_wstrb,
   input  logic              i_refill_valid,
   input  logic [DATA_W-1:0] i_refill_data,
   output logic              o_refill_ready,
   output logic              o_refill_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_par_err,
   output logic              o_busy
);

   localparam int ADDR_W = IDX_W + OFF_W;
   localparam int DEPTH  = SETS * WORDS_PER_LINE;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [IDX_W-1:0]   r_crit_idx;
   logic [OFF_W-1:0]   r_crit_off;
   logic [OFF_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_rvalid;

   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_idle;
   logic               w_hit_rd;
   logic               w_hit_wr;
   logic               w_miss;
   logic               w_beat;
   logic [ADDR_W-1:0]  w_req_addr;
   logic [OFF_W-1:0]   w_fill_off;
   logic [ADDR_W-1:0]  w_fill_addr;
   logic [DATA_W-1:0]  w_old;
   logic [DATA_W-1:0]  w_merged;

   assign w_idle     = (r_state == IDLE);
   assign w_hit_rd   = w_idle & i_rd_en & i_hit;
   assign w_hit_wr   = w_idle & i_wr_en & i_hit;
   assign w_miss     = w_idle & i_rd_en & ~i_hit;
   assign w_beat     = (r_state == REFILL) & i_refill_valid;

   assign w_req_addr = {i_index, i_offset};
   // Beat k lands at (crit_off + k); the OFF_W-bit sum wraps within the line.
   assign w_fill_off  = r_crit_off + r_cnt;
   assign w_fill_addr = {r_crit_idx, w_fill_off};

   // Current word at the request address: read-hit data and the base for the
   // byte-strobe merge of a write hit.
   assign w_old = r_mem[w_req_addr];

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign w_merged[gi*8 +: 8] = i_wstrb[gi] ? i_wdata[gi*8 +: 8] : w_old[gi*8 +: 8];
   end

   // Data array (contents are never reset)
   always_ff @(posedge i_clk) begin
      if (w_hit_wr) begin
         r_mem[w_req_addr] <= w_merged;
      end else if (w_beat) begin
         r_mem[w_fill_addr] <= i_refill_data;
      end
   end

`ifdef CACHE_PARITY_EN
   logic r_par [DEPTH];
   logic r_par_err;

   always_ff @(posedge i_clk) begin
      if (w_hit_wr) begin
         r_par[w_req_addr] <= ^w_merged;
      end else if (w_beat) begin
         r_par[w_fill_addr] <= ^i_refill_data;
      end
   end

   // Error flag pulses with rvalid; the forwarded critical word is never flagged.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= w_hit_rd & ((^w_old) ^ r_par[w_req_addr]);
      end
   end

   assign o_par_err = r_par_err;
`else
   assign o_par_err = 1'b0;
`endif

   // State, refill bookkeeping and read-data register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_crit_idx <= '0;
         r_crit_off <= '0;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_rvalid <= 1'b0;
         if (w_hit_rd) begin
            r_rdata  <= w_old;
            r_rvalid <= 1'b1;
         end
         if (w_miss) begin
            r_crit_idx <= i_index;
            r_crit_off <= i_offset;
            r_cnt      <= '0;
         end
         if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0) begin
               r_rdata  <= i_refill_data;
               r_rvalid <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_miss) w_state_next = REFILL;
         REFILL:  if (w_beat && (r_cnt == LAST_BEAT)) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign o_refill_ready = (r_state == REFILL);
   assign o_refill_done  = (r_state == DONE);
   assign o_busy         = ~w_idle;
   assign o_rdata        = r_rdata;
   assign o_rvalid       = r_rvalid;

endmodule

// File: tb/tb_cache_line_store.sv
module tb_cache_line_store;

   localparam int DATA_W = 32;
   localparam int WPL    = 4;
   localparam int SETS   = 32;

   logic        clk;
   logic        reset_n;
   logic        rd_en;
   logic        wr_en;
   logic        hit;
   logic [4:0]  index;
   logic [1:0]  offset;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        refill_valid;
   logic [31:0] refill_data;
   logic        refill_ready;
   logic        refill_done;
   logic [31:0] rdata;
   logic        rvalid;
   logic        par_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   cache_line_store #(
      .DATA_W(DATA_W),
      .WORDS_PER_LINE(WPL),
      .SETS(SETS)
   ) dut (
      .i_clk(clk),
      .i_reset_n(reset_n),
      .i_rd_en(rd_en),
      .i_wr_en(wr_en),
      .i_hit(hit),
      .i_index(index),
      .i_offset(offset),
      .i_wdata(wdata),
      .i_wstrb(wstrb),
      .i_refill_valid(refill_valid),
      .i_refill_data(refill_data),
      .o_refill_ready(refill_ready),
      .o_refill_done(refill_done),
      .o_rdata(rdata),
      .o_rvalid(rvalid),
      .o_par_err(par_err),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rd_en = 1'b0; wr_en = 1'b0; hit = 1'b0;
      wdata = '0; wstrb = '0;
      refill_valid = 1'b0; refill_data = '0;
   endtask

   // Read miss at (idx,off), then WPL beats base+k with 'gap' idle cycles
   // before each beat; rd_en with hit is held during gaps and must be ignored.
   task automatic refill(input logic [4:0] idx, input logic [1:0] off,
                         input logic [31:0] base, input int gap);
      @(negedge clk);
      rd_en = 1'b1; hit = 1'b0; index = idx; offset = off;
      @(posedge clk); #1;
      check("miss_busy", 32'(busy), 32'd1);
      check("miss_ready", 32'(refill_ready), 32'd1);
      for (int k = 0; k < WPL; k++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            refill_valid = 1'b0; rd_en = 1'b1; hit = 1'b1;
            @(posedge clk); #1;
            check("gap_rvalid", 32'(rvalid), 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
         end
         @(negedge clk);
         rd_en = 1'b0; hit = 1'b0;
         refill_valid = 1'b1; refill_data = base + 32'(k);
         @(posedge clk); #1;
         check("beat_rvalid", 32'(rvalid), (k == 0) ? 32'd1 : 32'd0);
         if (k == 0) check("crit_rdata", rdata, base);
         check("beat_done", 32'(refill_done), (k == WPL-1) ? 32'd1 : 32'd0);
         check("beat_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      refill_valid = 1'b0;
      @(posedge clk); #1;
      check("post_done", 32'(refill_done), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic        h;
      logic [4:0]  idx;
      logic [1:0]  off;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic        exp_rv;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[20];

   initial begin
      // rd wr hit idx off wdata wstrb exp_rvalid exp_rdata
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'd5,  2'd0, 32'h0, 4'h0, 1'b1, 32'h000000A2};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 5'd5,  2'd1, 32'h0, 4'h0, 1'b1, 32'h000000A3};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'd5,  2'd2, 32'h0, 4'h0, 1'b1, 32'h000000A0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 5'd5,  2'd3, 32'h0, 4'h0, 1'b1, 32'h000000A1};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'd5,  2'd0, 32'hDEADBEEF, 4'b0101, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'd5,  2'd0, 32'h0, 4'h0, 1'b1, 32'h00AD00EF};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd6,  2'd1, 32'h12345678, 4'hF, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd6,  2'd1, 32'h0, 4'h0, 1'b1, 32'h000000C1};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd6,  2'd2, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'd6,  2'd2, 32'h0, 4'h0, 1'b1, 32'h000000C2};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd6,  2'd3, 32'h11223344, 4'b1000, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 5'd6,  2'd3, 32'h0, 4'h0, 1'b1, 32'h110000C3};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 5'd31, 2'd0, 32'h0, 4'h0, 1'b1, 32'h000000B1};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 5'd31, 2'd1, 32'h0, 4'h0, 1'b1, 32'h000000B2};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 5'd31, 2'd2, 32'h0, 4'h0, 1'b1, 32'h000000B3};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 5'd7,  2'd1, 32'h0, 4'h0, 1'b1, 32'h00000170};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 5'd7,  2'd3, 32'h0, 4'h0, 1'b1, 32'h00000172};
      vecs[17] = '{1'b1, 1'b0, 1'b1, 5'd7,  2'd0, 32'h0, 4'h0, 1'b1, 32'h00000173};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 5'd6,  2'd0, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0};
      vecs[19] = '{1'b1, 1'b0, 1'b1, 5'd6,  2'd0, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D};

      idle_inputs();
      index = '0; offset = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_ready", 32'(refill_ready), 32'd0);
      check("rst_done", 32'(refill_done), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_par", 32'(par_err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Abort a refill after two beats with an asynchronous reset.
      @(negedge clk);
      rd_en = 1'b1; hit = 1'b0; index = 5'd7; offset = 2'd1;
      @(negedge clk);
      rd_en = 1'b0; refill_valid = 1'b1; refill_data = 32'h70;
      @(negedge clk);
      refill_data = 32'h71;
      @(negedge clk);
      refill_valid = 1'b0;
      #1;
      check("abort_busy_before", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_ready", 32'(refill_ready), 32'd0);
      check("async_rvalid", 32'(rvalid), 32'd0);
      check("async_done", 32'(refill_done), 32'd0);
      check("async_rdata", rdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Restart on the same line: must begin at beat 0 again.
      refill(5'd7, 2'd1, 32'h170, 0);
      // Main miss case, back-to-back beats.
      refill(5'd5, 2'd2, 32'hA0, 0);
      // Gapped refill, maximum index and offset (wraps 3 -> 0).
      refill(5'd31, 2'd3, 32'hB0, 2);
      refill(5'd6, 2'd0, 32'hC0, 1);

      // refill_valid while idle must not touch the array (checked by vecs[0..3]).
      @(negedge clk);
      refill_valid = 1'b1; refill_data = 32'hFFFF0000; index = 5'd5; offset = 2'd0;
      @(negedge clk);
      refill_valid = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         rd_en = vecs[i].rd; wr_en = vecs[i].wr; hit = vecs[i].h;
         index = vecs[i].idx; offset = vecs[i].off;
         wdata = vecs[i].wd; wstrb = vecs[i].ws;
         @(posedge clk); #1;
         check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rv));
         if (vecs[i].exp_rv) begin
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_par", i), 32'(par_err), 32'd0);
         end
         $display("vec %0d rd=%0b wr=%0b hit=%0b idx=%0d off=%0d rvalid=%0b rdata=%h",
                  i, vecs[i].rd, vecs[i].wr, vecs[i].h, vecs[i].idx, vecs[i].off, rvalid, rdata);
      end
      @(negedge clk);
      idle_inputs();

      // Single read hit at max index/offset: exactly one-cycle rvalid, data held.
      @(negedge clk);
      rd_en = 1'b1; hit = 1'b1; index = 5'd31; offset = 2'd3;
      @(posedge clk); #1;
      check("max_rvalid", 32'(rvalid), 32'd1);
      check("max_rdata", rdata, 32'hB0);
      @(negedge clk);
      rd_en = 1'b0;
      @(posedge clk); #1;
      check("max_rvalid_width", 32'(rvalid), 32'd0);
      check("max_rdata_hold", rdata, 32'hB0);

      // Parity: corrupt one stored bit of [5][1].
`ifdef CACHE_PARITY_EN
      dut.r_mem[5*WPL+1] = dut.r_mem[5*WPL+1] ^ 32'h0000_0100;
      @(negedge clk);
      rd_en = 1'b1; hit = 1'b1; index = 5'd5; offset = 2'd1;
      @(posedge clk); #1;
      check("perr_rvalid", 32'(rvalid), 32'd1);
      check("perr_rdata", rdata, 32'h000001A3);
      check("perr_flag", 32'(par_err), 32'd1);
      @(negedge clk);
      rd_en = 1'b0;
      @(posedge clk); #1;
      check("perr_pulse", 32'(par_err), 32'd0);
`else
      @(negedge clk);
      rd_en = 1'b1; hit = 1'b1; index = 5'd5; offset = 2'd1;
      @(posedge clk); #1;
      check("nopar_rvalid", 32'(rvalid), 32'd1);
      check("nopar_flag", 32'(par_err), 32'd0);
      @(negedge clk);
      rd_en = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_line_store.md
# cache_line_store

Parametrised direct-mapped cache data array with a burst refill engine, sitting between the cache controller (tag/hit logic) and the memory-side refill port of the single-cycle RISC-V core's data cache. It serves read hits with one-cycle registered latency and applies write-through hits with byte strobes. On a read miss it accepts a critical-word-first line burst, returning the requested word as soon as it arrives (early restart). Tags and valid bits live in the controller; this block stores data only.

## Interface
- DATA_W, 32, word width in bits (multiple of 8)
- WORDS_PER_LINE, 4, words per line (power of 2, >=2); OFF_W = $clog2(WORDS_PER_LINE)
- SETS, 32, number of lines (power of 2); IDX_W = $clog2(SETS)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_en  in  1  core read request (one-cycle qualifier)
- wr_en  in  1  core write request; rd_en and wr_en never both 1
- hit  in  1  controller tag-match result for current index
- index  in  IDX_W  set index
- offset  in  OFF_W  word offset in line
- wdata  in  DATA_W  store data
- wstrb  in  DATA_W/8  byte write enables
- refill_valid  in  1  refill beat valid
- refill_data  in  DATA_W  refill beat data
- refill_ready  out  1  block accepts refill beats
- refill_done  out  1  one-cycle pulse, line complete
- rdata  out  DATA_W  read data (registered)
- rvalid  out  1  one-cycle pulse, rdata valid
- par_err  out  1  parity error with rvalid (CACHE_PARITY_EN only)
- busy  out  1  refill in progress; controller stalls core

## Operation
- States: IDLE, REFILL, DONE.
- IDLE, rd_en & hit: word [index][offset] captured into rdata; rvalid pulses.
- IDLE, wr_en & hit: bytes with wstrb=1 of [index][offset] updated; others unchanged. No rvalid.
- IDLE, wr_en & !hit: no-write-allocate; array untouched.
- IDLE, rd_en & !hit: latch index/offset as crit_idx/crit_off, beat counter=0, go REFILL.
- REFILL: refill_ready=1. Each cycle with refill_valid & refill_ready, beat k written whole to word (crit_off + k) mod WORDS_PER_LINE (OFF_W wrap), counter++. Beat 0 also loaded into rdata, rvalid pulses. After beat WORDS_PER_LINE-1 go DONE. refill_valid low stalls without penalty.
- DONE: refill_done=1 for one cycle, then IDLE.
- busy = (state != IDLE). rd_en/wr_en while busy ignored (no array change, no rvalid).
- refill_valid in IDLE or DONE ignored.
- Reset (any time, incl. mid-refill): state IDLE, counter 0, all outputs 0. Array contents not cleared; partially refilled line undefined; controller must invalidate its tag.

## Timing
- Read hit: request cycle N, rdata/rvalid at N+1 for exactly one cycle.
- Write hit: array updated at the rising edge ending the request cycle; a read hit of the same word in the next cycle returns the new data.
- Read miss: busy rises at N+1; with back-to-back beats, beat k accepted at N+1+k; rvalid at N+2 (critical word); refill_done at N+1+WORDS_PER_LINE; busy falls the cycle after; new request accepted at N+2+WORDS_PER_LINE.
- rdata holds its last value between rvalid pulses; only rvalid qualifies it.

## Configuration
- CACHE_PARITY_EN defined: each stored word carries one even-parity bit, computed on write hits (over the merged word) and refill beats. On read hit, recomputed parity vs stored bit drives par_err, registered alongside rvalid. Critical-word early-restart returns par_err=0. par_err resets to 0.
- Not defined: no parity storage; par_err tied 0.

## Test plan
- Reset: assert reset_n=0 mid-refill after 2 beats -> state IDLE, busy/refill_ready/rvalid/refill_done=0 immediately (asynchronously); next read miss restarts at beat 0.
- Read miss index=5 offset=2, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> rvalid once with rdata=0xA0 one cycle after first beat; words 2,3,0,1 = A0,A1,A2,A3; refill_done after beat 4; read hits of offsets 0..3 return A2,A3,A0,A1.
- Refill with refill_valid gaps (beat, 2 idle cycles, beat, ...) -> same line contents; busy stays 1; rd_en during busy produces no rvalid.
- Write hit index=5 offset=0 wdata=0xDEADBEEF wstrb=4'b0101 over 0xA2 -> following read returns 0x00AD00EF; write miss to index=6 leaves index 6 unchanged.
- Read hit index=31 offset=3 after refill -> rdata at exactly N+1, rvalid width 1; index/offset wrap at max values verified.
- CACHE_PARITY_EN: clean read -> par_err=0; hierarchically flip one stored bit of [5][1] -> read gives par_err=1 with rvalid; macro undefined -> par_err=0.
